// File: rtl/fpmult_issue_arbiter.sv
// fpmult_issue_arbiter: round-robin two-requester issue arbiter for a pipelined FPMult core,
// returning products in issue order through a credit-reserved show-ahead result FIFO.
module fpmult_issue_arbiter #(
    parameter int WIDTH    = 16,
    parameter int EXPONENT = 5,
    parameter int LATENCY  = 4,
    parameter int DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             core_valid,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic [WIDTH-1:0] core_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_tag
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || EXPONENT >= WIDTH - 1) begin : g_bad_params
        $error("fpmult_issue_arbiter: illegal parameter set");
    end

    logic [CW-1:0]      credit_q, credit_d, cnt_q, cnt_d;
    logic               ptr_q, ptr_d;
    logic               core_valid_q, core_tag_q;
    logic [WIDTH-1:0]   core_a_q, core_b_q;
    logic [LATENCY-1:0] pipe_v_q, pipe_t_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               tag_mem_q [DEPTH];
    logic [AW-1:0]      rd_q, wr_q;
    logic               avail, gnt0, gnt1, issue, push, pop;

    // A credit is held from issue until the response is popped, so a FIFO slot always waits for each product.
    always_comb begin
        avail    = !rst && credit_q != '0;
        gnt0     = avail && req0_valid && (!req1_valid || !ptr_q);
        gnt1     = avail && req1_valid && (!req0_valid || ptr_q);
        issue    = gnt0 || gnt1;
        push     = pipe_v_q[LATENCY-1];
        pop      = cnt_q != '0 && rsp_ready;
        credit_d = credit_q - CW'(issue) + CW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        ptr_d    = issue ? gnt0 : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q     <= CW'(DEPTH);
            cnt_q        <= '0;
            ptr_q        <= 1'b0;
            core_valid_q <= 1'b0;
            core_tag_q   <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            pipe_v_q     <= '0;
            pipe_t_q     <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
        end else begin
            credit_q     <= credit_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            core_valid_q <= issue;
            core_tag_q   <= gnt1;
            if (issue) begin
                core_a_q <= gnt1 ? req1_a : req0_a;
                core_b_q <= gnt1 ? req1_b : req0_b;
            end
            pipe_v_q <= LATENCY'({pipe_v_q, core_valid_q});
            pipe_t_q <= LATENCY'({pipe_t_q, core_tag_q});
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q]     <= core_result;
            tag_mem_q[wr_q] <= pipe_t_q[LATENCY-1];
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign core_valid = core_valid_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign rsp_valid  = cnt_q != '0;
    assign rsp_result = rsp_valid ? mem_q[rd_q] : '0;
    assign rsp_tag    = rsp_valid && tag_mem_q[rd_q];

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == CW'(DEPTH)));
endmodule
